// File: rtl/fft8_bf_sched.sv
// fft8_bf_sched: sequencer for an 8-point radix-2 DIT FFT built around one
// shared butterfly unit. Walks the 3 stages x 4 butterflies, drives the two
// operand-mux selects and the twiddle index, and replays the in-place
// destination addresses BF_LAT cycles later as write-back strobes. A drain
// gap of BF_LAT cycles after each stage keeps the next stage from reading a
// result that has not yet been written back.
module fft8_bf_sched #(
   parameter int BF_LAT = 2 // butterfly latency, operand select -> result valid (1..4)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       src_in,
   output logic [2:0] sel_a,
   output logic [2:0] sel_b,
   output logic [1:0] tw_idx,
   output logic       issue,
   output logic [1:0] stage,
   output logic       wr_en,
   output logic [2:0] wr_addr_a,
   output logic [2:0] wr_addr_b
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // One write-back slot: valid flag plus the two in-place destinations.
   typedef struct packed {
      logic       vld;
      logic [2:0] a;
      logic [2:0] b;
   } wb_t;

   localparam logic [2:0] CNT_LAST = 3'(BF_LAT - 1);

   // Butterfly j of stage s -> {a, b, k}:
   //   span = 2^s, pos = j mod span, grp = j >> s
   //   a = grp*2*span + pos, b = a + span, k = pos << (2-s)
   function automatic logic [7:0] bf_addr(input logic [1:0] s, input logic [1:0] j);
      logic [2:0] span;
      logic [2:0] pos;
      logic [2:0] grp;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] k;
      span = 3'd1 << s;
      pos  = {1'b0, j} & (span - 3'd1);
      grp  = {1'b0, j} >> s;
      a    = (grp << (s + 2'd1)) + pos;
      b    = a + span;
      k    = pos << (2'd2 - s);
      return {a, b, k[1:0]};
   endfunction

   // Reverse the three address bits (stage 0 reads the natural-order input
   // bank in bit-reversed order).
   function automatic logic [2:0] bitrev3(input logic [2:0] x);
      return {x[0], x[1], x[2]};
   endfunction

   // Sequencing state
   state_e     state_q, state_d;
   logic [1:0] stage_q, stage_d;   // stage being issued/drained
   logic [1:0] bf_q, bf_d;         // butterfly index within the stage
   logic [2:0] cnt_q, cnt_d;       // drain cycle counter

   // Registered outputs
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       src_in_q, src_in_d;
   logic [2:0] sel_a_q, sel_a_d;
   logic [2:0] sel_b_q, sel_b_d;
   logic [1:0] tw_idx_q, tw_idx_d;
   logic       issue_q, issue_d;
   logic [1:0] stage_o_q, stage_o_d;
   logic [2:0] wa_q, wa_d;         // natural-order destinations of the issued butterfly
   logic [2:0] wb_q, wb_d;

   // Write-back delay line; the last slot drives the write port directly
   wb_t pipe_q [BF_LAT];
   wb_t pipe_d [BF_LAT];

   // State register: sequencing counters and all registered outputs
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         stage_q   <= 2'd0;
         bf_q      <= 2'd0;
         cnt_q     <= 3'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         src_in_q  <= 1'b0;
         sel_a_q   <= 3'd0;
         sel_b_q   <= 3'd0;
         tw_idx_q  <= 2'd0;
         issue_q   <= 1'b0;
         stage_o_q <= 2'd0;
         wa_q      <= 3'd0;
         wb_q      <= 3'd0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         bf_q      <= bf_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         src_in_q  <= src_in_d;
         sel_a_q   <= sel_a_d;
         sel_b_q   <= sel_b_d;
         tw_idx_q  <= tw_idx_d;
         issue_q   <= issue_d;
         stage_o_q <= stage_o_d;
         wa_q      <= wa_d;
         wb_q      <= wb_d;
      end
   end

   // Next-state logic: IDLE -> (ISSUE x4 -> DRAIN xBF_LAT) x3 -> DONE -> IDLE
   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      bf_d    = bf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               stage_d = 2'd0;
               bf_d    = 2'd0;
            end
         end
         S_ISSUE: begin
            if (bf_q == 2'd3) begin
               state_d = S_DRAIN;
               cnt_d   = 3'd0;
            end else begin
               bf_d = bf_q + 2'd1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_LAST) begin
               if (stage_q == 2'd2) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  stage_d = stage_q + 2'd1;
                  bf_d    = 2'd0;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: derived from the next state so the registered outputs
   // line up with the state they describe
   always_comb begin
      logic [7:0] abk;
      abk       = bf_addr(stage_d, bf_d);
      busy_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_d    = (state_d == S_DONE);
      issue_d   = (state_d == S_ISSUE);
      stage_o_d = busy_d ? stage_d : 2'd0;
      src_in_d  = 1'b0;
      sel_a_d   = 3'd0;
      sel_b_d   = 3'd0;
      tw_idx_d  = 2'd0;
      wa_d      = 3'd0;
      wb_d      = 3'd0;
      if (issue_d) begin
         wa_d     = abk[7:5];
         wb_d     = abk[4:2];
         tw_idx_d = abk[1:0];
         if (stage_d == 2'd0) begin
            src_in_d = 1'b1;
            sel_a_d  = bitrev3(abk[7:5]);
            sel_b_d  = bitrev3(abk[4:2]);
         end else begin
            sel_a_d = abk[7:5];
            sel_b_d = abk[4:2];
         end
      end
   end

   // Write-back delay line input: shift in the issued butterfly each cycle
   always_comb begin
      pipe_d[0] = '{vld: issue_q, a: wa_q, b: wb_q};
      for (int i = 1; i < BF_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Write-back delay line register
   // NOTE: this delay line is reset on purpose, unlike a data memory: a
   // stale valid bit surviving reset would fire a spurious write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BF_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < BF_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign src_in    = src_in_q;
   assign sel_a     = sel_a_q;
   assign sel_b     = sel_b_q;
   assign tw_idx    = tw_idx_q;
   assign issue     = issue_q;
   assign stage     = stage_o_q;
   assign wr_en     = pipe_q[BF_LAT-1].vld;
   assign wr_addr_a = pipe_q[BF_LAT-1].a;
   assign wr_addr_b = pipe_q[BF_LAT-1].b;

endmodule

// File: tb/tb_fft8_bf_sched.sv
// tb_fft8_bf_sched: drives two sequencer instances (BF_LAT=2 and BF_LAT=4).
// Accepted starts push the expected issue, write-back and done events into
// queues; a negedge monitor pops and compares them against the DUT outputs
// every cycle, and expects idle values whenever no event is due.
module tb_fft8_bf_sched;

   localparam int LAT [2] = '{2, 4};

   // Butterfly table in issue order (stage-major): natural a, b and k
   localparam int TA [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   localparam int TB [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   localparam int TK [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
   // Stage-0 operand selects (bit-reversed reads of the input bank)
   localparam int SA0 [4] = '{0, 2, 1, 3};
   localparam int SB0 [4] = '{4, 6, 5, 7};

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       src_in;
      logic [2:0] sel_a;
      logic [2:0] sel_b;
      logic [1:0] tw_idx;
      logic       issue;
      logic [1:0] stage;
      logic       wr_en;
      logic [2:0] wr_addr_a;
      logic [2:0] wr_addr_b;
   } obs_t;

   typedef struct {
      int         dut;
      int         cyc;
      logic       src;
      logic [2:0] x;     // sel_a (issue) or wr_addr_a (write-back)
      logic [2:0] y;     // sel_b (issue) or wr_addr_b (write-back)
      logic [1:0] k;
      logic [1:0] s;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start2, start4;
   obs_t o [2];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   ev_t iss_q  [$];
   ev_t wr_q   [$];
   ev_t done_q [$];
   int  busy_lo [2];
   int  busy_hi [2];
   int  free_c  [2];   // first cycle in which the DUT is back in IDLE

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft8_bf_sched #(.BF_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .busy(o[0].busy), .done(o[0].done), .src_in(o[0].src_in),
      .sel_a(o[0].sel_a), .sel_b(o[0].sel_b), .tw_idx(o[0].tw_idx),
      .issue(o[0].issue), .stage(o[0].stage), .wr_en(o[0].wr_en),
      .wr_addr_a(o[0].wr_addr_a), .wr_addr_b(o[0].wr_addr_b)
   );

   fft8_bf_sched #(.BF_LAT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .busy(o[1].busy), .done(o[1].done), .src_in(o[1].src_in),
      .sel_a(o[1].sel_a), .sel_b(o[1].sel_b), .tw_idx(o[1].tw_idx),
      .issue(o[1].issue), .stage(o[1].stage), .wr_en(o[1].wr_en),
      .wr_addr_a(o[1].wr_addr_a), .wr_addr_b(o[1].wr_addr_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // Start accepted in cycle c: queue everything the transform must produce
   task automatic push_xform(input int d, input int c);
      int   l;
      int   t;
      int   s;
      int   j;
      ev_t  e;
      l = LAT[d];
      for (int n = 0; n < 12; n++) begin
         s = n / 4;
         j = n % 4;
         t = c + 1 + s * (4 + l) + j;
         e.dut = d; e.cyc = t; e.s = 2'(s); e.k = 2'(TK[n]);
         e.src = (s == 0);
         e.x   = (s == 0) ? 3'(SA0[j]) : 3'(TA[n]);
         e.y   = (s == 0) ? 3'(SB0[j]) : 3'(TB[n]);
         iss_q.push_back(e);
         e.cyc = t + l; e.x = 3'(TA[n]); e.y = 3'(TB[n]);
         e.src = 1'b0; e.k = 2'd0; e.s = 2'd0;
         wr_q.push_back(e);
      end
      e.cyc = c + 1 + 3 * (4 + l);
      done_q.push_back(e);
      busy_lo[d] = c + 1;
      busy_hi[d] = c + 3 * (4 + l);
      free_c[d]  = c + 2 + 3 * (4 + l);
   endtask

   // Reset drops every pending expectation
   task automatic reset_model();
      iss_q.delete();
      wr_q.delete();
      done_q.delete();
      for (int d = 0; d < 2; d++) begin
         busy_lo[d] = 1;
         busy_hi[d] = 0;
         free_c[d]  = cyc;
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) start2 = v;
      else        start4 = v;
      if (v && rst_n && cyc >= free_c[d]) push_xform(d, cyc);
   endtask

   task automatic monitor(input int d);
      obs_t  ob;
      ev_t   e;
      logic  exp_b;
      logic  hit;
      string lt;
      ob    = o[d];
      lt    = $sformatf("L%0d", LAT[d]);
      exp_b = (cyc >= busy_lo[d]) && (cyc <= busy_hi[d]);
      check({lt, " busy"}, 32'(ob.busy), 32'(exp_b));

      hit = (iss_q.size() > 0) && (iss_q[0].dut == d) && (iss_q[0].cyc == cyc);
      check({lt, " issue"}, 32'(ob.issue), 32'(hit));
      if (hit) begin
         e = iss_q.pop_front();
         check({lt, " src/sel_a/sel_b/tw/stage"},
               32'({ob.src_in, ob.sel_a, ob.sel_b, ob.tw_idx, ob.stage}),
               32'({e.src, e.x, e.y, e.k, e.s}));
      end else begin
         check({lt, " idle selects"},
               32'({ob.src_in, ob.sel_a, ob.sel_b, ob.tw_idx}), 32'(0));
      end

      hit = (wr_q.size() > 0) && (wr_q[0].dut == d) && (wr_q[0].cyc == cyc);
      check({lt, " wr_en"}, 32'(ob.wr_en), 32'(hit));
      if (hit) begin
         e = wr_q.pop_front();
         check({lt, " wr_addr_a/b"}, 32'({ob.wr_addr_a, ob.wr_addr_b}), 32'({e.x, e.y}));
      end

      hit = (done_q.size() > 0) && (done_q[0].dut == d) && (done_q[0].cyc == cyc);
      check({lt, " done"}, 32'(ob.done), 32'(hit));
      if (hit) void'(done_q.pop_front());
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) monitor(d);
   end

   initial begin
      rst_n  = 1'b0;
      start2 = 1'b0;
      start4 = 1'b0;
      reset_model();
      repeat (3) step();
      rst_n = 1'b1;
      reset_model();

      // Quiet after reset: everything must stay at zero
      repeat (20) step();

      // One transform on BF_LAT=2, with starts at +5 (busy) and +19 (DONE) ignored
      for (int i = 0; i < 32; i++) begin
         step();
         set_start(0, (i == 0) || (i == 5) || (i == 19));
      end

      // Reset pulse at +9 of a transform: outputs clear at once, pending writes vanish
      for (int i = 0; i < 16; i++) begin
         step();
         if (i == 9) begin
            rst_n = 1'b0;
            reset_model();
            #1;
            check("async reset outputs", 32'(o[0]), 32'(0));
         end else if (i == 10) begin
            rst_n = 1'b1;
            reset_model();
         end
         set_start(0, i == 0);
      end

      // A fresh transform after the aborted one
      for (int i = 0; i < 24; i++) begin
         step();
         set_start(0, i == 0);
      end

      // start held high: back-to-back transforms with one IDLE cycle between
      for (int i = 0; i < 46; i++) begin
         step();
         set_start(0, i < 40);
      end

      // BF_LAT=4 transform: done 25 cycles after the start
      for (int i = 0; i < 32; i++) begin
         step();
         set_start(1, i == 0);
      end

      step();
      check("events left unmatched",
            32'(iss_q.size() + wr_q.size() + done_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft8_bf_sched.md
Name: fft8_bf_sched

Overview:
- Sequencer for the 8-point radix-2 DIT FFT datapath.
- Issues the 12 butterflies (3 stages × 4) to one shared butterfly unit.
- Each cycle, drives the 3-bit selects of the two 8:1 operand muxes (operand A, operand B) and the twiddle index.
- Generates delayed in-place write-back addresses and inserts drain cycles so no stage reads a result that has not yet been written.

Parameters:
- BF_LAT, 2: butterfly pipeline latency in cycles, from operand select to result valid; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a transform; sampled only in IDLE
- busy  output  1  high while in ISSUE or DRAIN
- done  output  1  one-cycle pulse after the last write-back
- src_in  output  1  operand muxes read the input sample bank (1) or the working register bank (0)
- sel_a  output  3  select for operand-A 8:1 mux
- sel_b  output  3  select for operand-B 8:1 mux
- tw_idx  output  2  twiddle exponent k of W8^k
- issue  output  1  sel_a/sel_b/tw_idx valid this cycle
- stage  output  2  current stage 0..2
- wr_en  output  1  write butterfly results to the working bank
- wr_addr_a  output  3  destination of butterfly upper output
- wr_addr_b  output  3  destination of butterfly lower output

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - All outputs 0.
  - Write-back delay line cleared; pending writes are dropped.
  - Deassertion mid-transform restarts in IDLE; no done is produced.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 → ISSUE with stage=0, bf=0.
  - ISSUE: 4 consecutive cycles, bf=0..3, issue=1; after bf=3 → DRAIN.
  - DRAIN: exactly BF_LAT cycles, issue=0. Then → ISSUE with stage+1 if stage<2, else → DONE.
  - DONE: one cycle, done=1, busy=0 → IDLE.
- start outside IDLE is ignored (not queued). start held high causes back-to-back transforms, with one IDLE cycle between them.
- Address rule in stage s, butterfly j:
  - span=2^s, pos=j mod span, grp=j>>s
  - a=grp·2·span+pos; b=a+span
  - k=pos<<(2−s)
- Results per stage:
  - s=0: (a,b,k) = (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - s=1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - s=2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- Stage 0:
  - src_in=1.
  - sel_a=bitrev3(a), sel_b=bitrev3(b), giving natural-order input read in bit-reversed order.
- Stages 1–2: src_in=0, sel_a=a, sel_b=b.
- Write-back:
  - {issue, a, b} passes through a BF_LAT-deep shift register.
  - wr_en, wr_addr_a and wr_addr_b are its output.
  - Issue at cycle t → wr_en at t+BF_LAT.
  - Writes are in place: wr_addr_a=a, wr_addr_b=b (natural, not bit-reversed).
- Hazard guarantee: the first read of stage s+1 occurs strictly after the cycle carrying the last wr_en of stage s.
- Timing: start accepted at cycle 0 gives
  - total busy cycles = 3·(4+BF_LAT)
  - done at cycle 3·(4+BF_LAT)+1
  - the last wr_en falls in the final DRAIN cycle.
- Outside ISSUE: sel_a, sel_b, tw_idx and src_in hold 0.

Test Plan:
- Reset with rst_n=0, then release with start=0 → all outputs 0, FSM stays IDLE, busy=0, with no activity for 20 cycles.
- BF_LAT=2, start pulse at cycle 0 → issue high at cycles 1–4, 7–10 and 13–16; wr_en high at 3–6, 9–12 and 15–18; busy high at 1–18; done only at 19.
  - Cycle-1 outputs: src_in=1, sel_a=0, sel_b=4, tw_idx=0.
  - Cycle-16 outputs: sel_a=3, sel_b=7, tw_idx=3.
- Stage-1 triples, checked against the table: cycle 8 → sel_a=2, sel_b=6, tw_idx=0 at src_in=1? No: stage 1 has src_in=0, so cycle 8 → sel_a=1, sel_b=3, tw_idx=2. wr_addr_a/b at cycle 10 = 1/3.
- start pulses at cycles 5 and 19 (busy, DONE) → ignored. Done count is 1, and the transform timing is unchanged.
- rst_n pulled low at cycle 9 for 1 cycle → all outputs 0 immediately (asynchronous). Pending wr_en at cycles 10–12 is absent and done never asserts. A new start then gives a full, correct sequence.
- BF_LAT=4, one start → done at cycle 25; wr_en/issue offset = 4 cycles; no wr_en in a cycle where the next stage's issue=1 precedes it.
